// File: rtl/data_memory_ctrl_pkg.sv
// data_memory_ctrl_pkg
// Shared definitions for the data memory controller:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILLEGAL)
//   - controller FSM state enum
//   - byte-lane mask constants and small helpers for size masks and
//     alignment checks
package data_memory_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
  localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

  // Right-aligned mask covering the lanes of one access of the given size.
  function automatic logic [31:0] size_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      SZ_BYTE: m = LANE_MASK_BYTE;
      SZ_HALF: m = LANE_MASK_HALF;
      SZ_WORD: m = LANE_MASK_WORD;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  // Illegal size, odd half address, or word not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter. Grant is combinational from req and the
// last-granted port; the last-granted port only moves when advance is high.
// Ports:
//   clk, rst_n     clock, async active-low reset (last grant resets to port 1)
//   req[1:0]       request per port
//   advance        commit the current grant as "last granted"
//   grant[1:0]     one-hot grant (zero when nothing requests)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_last;

  // On a tie, hand the grant to the port that did not win last time.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Resetting to port 1 makes port 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      r_last <= grant[1];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
// Arbitrates two requesters (port 0 = CPU, port 1 = loader/DMA) onto a
// single word-wide data memory, one transaction at a time. Sub-word stores
// are done as read-modify-write; loads are lane-extracted and zero-extended.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   req[N_REQ-1:0]           level request per port
//   addr0/1, wdata0/1        byte address and right-aligned store data
//   wr0/1, size0/1           1 = store; size 0/1/2 = byte/half/word
//   ack[N_REQ-1:0]           one-cycle one-hot completion pulse
//   err, rdata               status and load result, valid with ack
//   mem_addr, mem_wdata      word address / full write word to memory
//   mem_wren                 word write enable
//   mem_rdata                combinational read data at mem_addr
module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [31:0]      addr0,
  input  logic [31:0]      addr1,
  input  logic [31:0]      wdata0,
  input  logic [31:0]      wdata1,
  input  logic             wr0,
  input  logic             wr1,
  input  logic [1:0]       size0,
  input  logic [1:0]       size1,
  output logic [N_REQ-1:0] ack,
  output logic             err,
  output logic [31:0]      rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_wren,
  input  logic [31:0]      mem_rdata
);

  state_e      r_state;
  logic        r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wr;
  logic [1:0]  r_size;
  logic        r_err;
  logic [31:0] r_word;

  logic [1:0]  w_grant;
  logic        w_advance;
  logic        w_port;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_wr;
  logic [1:0]  w_size;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size);
    return (word >> {offset, 3'b000}) & size_mask(size);
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  offset,
                                             input logic [1:0]  size);
    logic [31:0] m;
    m = size_mask(size) << {offset, 3'b000};
    return (word & ~m) | ((data << {offset, 3'b000}) & m);
  endfunction

  assign w_advance = (r_state == ST_IDLE) && (req != '0);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (w_advance),
    .grant   (w_grant)
  );

  assign w_port  = w_grant[1];
  assign w_addr  = w_port ? addr1  : addr0;
  assign w_wdata = w_port ? wdata1 : wdata0;
  assign w_wr    = w_port ? wr1    : wr0;
  assign w_size  = w_port ? size1  : size0;

  // Requester inputs are only looked at in IDLE; everything afterwards
  // runs from the latched copy. The memory word is always captured in
  // ACCESS so sub-word stores can merge into it during WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wr    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_err   <= 1'b0;
      r_word  <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_advance) begin
            r_sel   <= w_port;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_wr    <= w_wr;
            r_size  <= w_size;
            r_err   <= is_misaligned(w_size, w_addr[1:0]);
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_word <= mem_rdata;
          if (!r_err && r_wr && (r_size != SZ_WORD)) begin
            r_state <= ST_WRITE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_WRITE: r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from state so reset clears them immediately. Word
  // stores write straight through in ACCESS; sub-word stores write the
  // merged word in WRITE. Misaligned accesses never write.
  always_comb begin
    mem_addr  = {r_addr[31:2], 2'b00};
    mem_wdata = 32'h0;
    mem_wren  = 1'b0;
    ack       = '0;
    err       = 1'b0;
    rdata     = 32'h0;
    case (r_state)
      ST_ACCESS: begin
        if (r_wr && !r_err && (r_size == SZ_WORD)) begin
          mem_wren  = 1'b1;
          mem_wdata = r_wdata;
        end
      end
      ST_WRITE: begin
        mem_wren  = 1'b1;
        mem_wdata = lane_merge(r_word, r_wdata, r_addr[1:0], r_size);
      end
      ST_DONE: begin
        ack[r_sel] = 1'b1;
        err        = r_err;
        if (!r_wr && !r_err) begin
          rdata = lane_extract(r_word, r_addr[1:0], r_size);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl
// Self-checking bench for data_memory_ctrl. A byte-addressed reference
// memory predicts load data, store effects, err and ack latency; the DUT
// talks to a separate word-wide memory that the bench only updates from
// mem_wren/mem_wdata, and the two are compared at the end.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        wr0, wr1;
  logic [1:0]  size0, size1;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_wren;

  int checks = 0;
  int errors = 0;

  logic [31:0] memWords [0:127];
  logic [7:0]  refBytes [0:511];
  int          wrenCount = 0;
  logic [31:0] lastWdata = 32'h0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.N_REQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .wr0       (wr0),
    .wr1       (wr1),
    .size0     (size0),
    .size1     (size1),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata)
  );

  // Word-wide data memory seen by the DUT.
  assign mem_rdata = memWords[mem_addr[8:2]];

  always @(posedge clk) begin
    if (mem_wren) memWords[mem_addr[8:2]] <= mem_wdata;
  end

  // Count write-enable cycles and remember the last written word.
  always @(negedge clk) begin
    if (mem_wren) begin
      wrenCount <= wrenCount + 1;
      lastWdata <= mem_wdata;
    end
  end

  task automatic set_word(input int byteAddr, input logic [31:0] value);
    for (int i = 0; i < 4; i++) refBytes[byteAddr + i] = value[8*i +: 8];
    memWords[byteAddr / 4] = value;
  endtask

  function automatic logic [31:0] ref_word(input int w);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = refBytes[4*w + i];
    return v;
  endfunction

  // One transaction from a single requester, checked against the byte model.
  task automatic do_txn(input int port, input logic [31:0] a, input logic [31:0] wd,
                        input logic w, input logic [1:0] sz, input bit dropEarly,
                        output logic [31:0] obsRdata);
    bit          misal;
    int          nBytes;
    logic [31:0] expRdata;
    int          expLat;
    int          expWrites;
    int          wrenBase;
    int          k;
    bit          seen;
    logic [1:0]  expAck;
    int          ba;
    ba        = int'(a[8:0]);
    misal     = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    nBytes    = 1 << sz;
    expRdata  = 32'h0;
    if (!w && !misal)
      for (int i = 0; i < nBytes; i++) expRdata[8*i +: 8] = refBytes[ba + i];
    expLat    = (!misal && w && sz != 2'd2) ? 3 : 2;
    expWrites = (!misal && w) ? 1 : 0;
    expAck    = (port == 0) ? 2'b01 : 2'b10;

    @(negedge clk);
    if (port == 0) begin
      addr0 = a; wdata0 = wd; wr0 = w; size0 = sz;
    end else begin
      addr1 = a; wdata1 = wd; wr1 = w; size1 = sz;
    end
    req[port] = 1'b1;
    wrenBase = wrenCount;

    // Granting edge; afterwards the requester inputs must not matter.
    @(posedge clk); #1;
    if (dropEarly) req[port] = 1'b0;
    addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
    wr0 = 1'($urandom); wr1 = 1'($urandom); size0 = 2'($urandom); size1 = 2'($urandom);

    // Ack is sampled on edge grant+expLat, so it is first visible just
    // after edge grant+expLat-1.
    k = 1; seen = 0;
    while (k <= 6 && !seen) begin
      @(posedge clk); #1;
      if (ack != 2'b00) seen = 1;
      else k++;
    end
    obsRdata = rdata;
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL txn_ack_timeout port=%0d addr=%h: no ack within 6 cycles", port, a);
    end else begin
      checks++;
      if (k + 1 !== expLat) begin
        errors++;
        $display("[TB] FAIL txn_latency addr=%h size=%0d wr=%0d: got %0d expected %0d", a, sz, w, k + 1, expLat);
      end
      checks++;
      if (ack !== expAck) begin
        errors++;
        $display("[TB] FAIL txn_ack_port: got %b expected %b", ack, expAck);
      end
      checks++;
      if (err !== misal) begin
        errors++;
        $display("[TB] FAIL txn_err addr=%h size=%0d: got %b expected %b", a, sz, err, misal);
      end
      if (!w || misal) begin
        checks++;
        if (rdata !== expRdata) begin
          errors++;
          $display("[TB] FAIL txn_rdata addr=%h size=%0d: got %h expected %h", a, sz, rdata, expRdata);
        end
      end
      checks++;
      if (wrenCount - wrenBase !== expWrites) begin
        errors++;
        $display("[TB] FAIL txn_wren_cycles addr=%h: got %0d expected %0d", a, wrenCount - wrenBase, expWrites);
      end
    end

    if (w && !misal)
      for (int i = 0; i < nBytes; i++) refBytes[ba + i] = wd[8*i +: 8];

    // Requester drops req on the edge that samples ack; ack must be gone.
    @(posedge clk); #1;
    req[port] = 1'b0;
    checks++;
    if (ack !== 2'b00) begin
      errors++;
      $display("[TB] FAIL txn_ack_width: got %b expected 00", ack);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b00;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    wr0 = 0; wr1 = 0; size0 = 0; size1 = 0;
    for (int w = 0; w < 128; w++) set_word(4 * w, $urandom);
    repeat (2) @(negedge clk);
    checks += 6;
    if (ack !== 2'b00)       begin errors++; $display("[TB] FAIL reset_ack: got %b expected 00", ack); end
    if (err !== 1'b0)        begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    if (rdata !== 32'h0)     begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    if (mem_wren !== 1'b0)   begin errors++; $display("[TB] FAIL reset_wren: got %b expected 0", mem_wren); end
    if (mem_addr !== 32'h0)  begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr); end
    if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", mem_wdata); end
    rst_n = 1'b1;
  endtask

  // Both ports hold req: port 0 wins first after reset, then they alternate.
  task automatic test_round_robin();
    int         nAck;
    logic [1:0] prevAck;
    logic [1:0] expAck;
    logic [31:0] expRd;
    @(negedge clk);
    addr0 = 32'h10; addr1 = 32'h20; wr0 = 0; wr1 = 0; size0 = 2'd2; size1 = 2'd2;
    req = 2'b11;
    nAck = 0; prevAck = 2'b00;
    for (int cyc = 0; cyc < 40 && nAck < 4; cyc++) begin
      @(posedge clk); #1;
      if (ack != 2'b00) begin
        expAck = (nAck % 2 == 0) ? 2'b01 : 2'b10;
        expRd  = (nAck % 2 == 0) ? ref_word(4) : ref_word(8);
        checks += 3;
        if (ack !== expAck) begin errors++; $display("[TB] FAIL rr_order #%0d: got %b expected %b", nAck, ack, expAck); end
        if (prevAck !== 2'b00) begin errors++; $display("[TB] FAIL rr_ack_width #%0d: previous %b expected 00", nAck, prevAck); end
        if (rdata !== expRd) begin errors++; $display("[TB] FAIL rr_rdata #%0d: got %h expected %h", nAck, rdata, expRd); end
        nAck++;
        if (nAck == 4) req = 2'b00;
      end
      prevAck = ack;
    end
    req = 2'b00;
    checks++;
    if (nAck !== 4) begin errors++; $display("[TB] FAIL rr_count: got %0d expected 4", nAck); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] r;
    set_word(32'h100, 32'h11223344);
    do_txn(0, 32'h102, 32'h0, 1'b0, 2'd0, 1'b0, r);
    checks++;
    if (r !== 32'h00000022) begin errors++; $display("[TB] FAIL byte_load_0x102: got %h expected 00000022", r); end
    do_txn(1, 32'h102, 32'h0000BEEF, 1'b1, 2'd1, 1'b0, r);
    checks++;
    if (lastWdata !== 32'hBEEF3344) begin errors++; $display("[TB] FAIL half_store_merge: got %h expected BEEF3344", lastWdata); end
    do_txn(0, 32'h101, 32'h0, 1'b0, 2'd2, 1'b0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("[TB] FAIL misaligned_word_rdata: got %h expected 0", r); end
    do_txn(0, 32'h100, 32'h0, 1'b0, 2'd2, 1'b1, r);
    checks++;
    if (r !== 32'hBEEF3344) begin errors++; $display("[TB] FAIL dropped_req_load: got %h expected BEEF3344", r); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int t = 0; t < 60; t++) begin
      do_txn(int'($urandom_range(0, 1)), 32'($urandom_range(0, 511)), $urandom,
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0), r);
    end
  endtask

  // Reset during WRITE of a byte store: no write lands, no ack follows.
  task automatic test_reset_mid_write();
    bit   sawWren;
    int   stray;
    logic [31:0] r;
    @(negedge clk);
    addr1 = 32'h40; wdata1 = 32'hA5; wr1 = 1'b1; size1 = 2'd0;
    req[1] = 1'b1;
    sawWren = 0;
    for (int c = 0; c < 5 && !sawWren; c++) begin
      @(posedge clk); #1;
      if (mem_wren) sawWren = 1;
    end
    checks++;
    if (!sawWren) begin errors++; $display("[TB] FAIL rst_mid_write_reach: got no WRITE cycle expected one"); end
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (mem_wren !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_write_wren: got %b expected 0", mem_wren); end
    if (ack !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_write_ack: got %b expected 00", ack); end
    req = 2'b00;
    #2 rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (ack != 2'b00 || mem_wren) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("[TB] FAIL rst_mid_write_quiet: got %0d active cycles expected 0", stray); end
    do_txn(0, 32'h40, 32'h0, 1'b0, 2'd2, 1'b0, r);
  endtask

  task automatic test_memory_image();
    for (int w = 0; w < 128; w++) begin
      checks++;
      if (memWords[w] !== ref_word(w)) begin
        errors++;
        $display("[TB] FAIL mem_image word %0d: got %h expected %h", w, memWords[w], ref_word(w));
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_directed();
    test_random();
    test_reset_mid_write();
    test_memory_image();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
